// File: rtl/prga_prog_ctrl_if.sv
// Wishbone slave bus bundle between the management SoC and the programming controller.
// The controller uses the slave modport and the SoC side (or testbench) uses the master modport.
// Signal names keep the SoC's Wishbone wbs_*_i / wbs_*_o naming.
interface prga_prog_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/prga_prog_ctrl.sv
// Wishbone-programmed bitstream loader: holds the fabric config chain in reset, then shifts FIFO words out LSB-first.
// Bus ack is 1 cycle after a hit. prog_* outputs come straight from the state and the shift register, with no added latency.
// Backpressure: an empty FIFO stalls the bit stream with prog_we low, and a push to a full FIFO is dropped and sets ovf.
// Optional feature macro PROG_CRC_EN puts a CRC-16-CCITT of the emitted bits in STATUS[31:16].
module prga_prog_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          RST_CYCLES = 4,
  parameter int          LEN_W      = 24
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  prga_prog_ctrl_if.slave wb,
  output logic            prog_rst,
  output logic            prog_we,
  output logic            prog_din,
  output logic            prog_done,
  output logic            irq
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int RCW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_STREAM, S_DONE} state_t;
  state_t state, state_nxt;

  // Bus decode. A hit is blocked while ack is high, so each access acks exactly once.
  logic       hit, wr;
  logic [1:0] reg_sel;
  logic       start, abort, clr_err, wr_len, push;
  assign hit     = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o &
                   (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr      = hit & wb.wbs_we_i;
  assign reg_sel = wb.wbs_adr_i[3:2];
  assign abort   = wr & (reg_sel == 2'd0) & wb.wbs_dat_i[1];
  assign start   = wr & (reg_sel == 2'd0) & wb.wbs_dat_i[0] & ~wb.wbs_dat_i[1];
  assign clr_err = wr & (reg_sel == 2'd0) & wb.wbs_dat_i[2];
  assign wr_len  = wr & (reg_sel == 2'd1);
  assign push    = wr & (reg_sel == 2'd2);

  logic unused_ok;
  assign unused_ok = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

  // Word FIFO with an extra pointer bit to tell full from empty.
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, flush, push_ok, ovf;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok = push & (~full | pop | flush);

  // Control/datapath registers.
  logic [LEN_W-1:0] len_q, rem;
  logic [RCW-1:0]   rst_cnt;
  logic [31:0]      sr;
  logic [5:0]       bit_cnt;
  logic             busy, emit, start_acc;
  assign busy      = (state == S_RST) || (state == S_STREAM);
  assign start_acc = start & ~busy;
  assign emit      = (state == S_STREAM) && (bit_cnt != 6'd0);

  assign prog_rst  = (state == S_RST);
  assign prog_we   = emit;
  assign prog_din  = emit & sr[0];
  assign prog_done = (state == S_DONE);
  assign irq       = prog_done | ovf;

  // Next state plus pop/flush strobes. ABORT overrides everything else.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    flush     = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start_acc) state_nxt = S_RST;
      S_RST: if (rst_cnt == RCW'(1)) state_nxt = (rem == '0) ? S_DONE : S_STREAM;
      S_STREAM: begin
        if (bit_cnt != 6'd0) begin
          if (rem == LEN_W'(1)) begin
            state_nxt = S_DONE;
            flush     = 1'b1;
          end
        end else if (!empty) begin
          pop = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) begin
      state_nxt = S_IDLE;
      flush     = 1'b1;
      pop       = 1'b0;
    end
  end

  // FIFO storage. It needs no reset because the pointers qualify every entry.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wb.wbs_dat_i;
  end

  // FIFO pointers. A flush keeps a word pushed in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + (AW+1)'(1);
      if (flush)    rptr <= wptr;
      else if (pop) rptr <= rptr + (AW+1)'(1);
    end
  end

  // State, counters, shift register and sticky overflow.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      len_q   <= '0;
      rem     <= '0;
      rst_cnt <= '0;
      sr      <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_len && !busy) len_q <= wb.wbs_dat_i[LEN_W-1:0];
      if (start_acc)               rst_cnt <= RCW'(RST_CYCLES);
      else if (state == S_RST)     rst_cnt <= rst_cnt - RCW'(1);
      if (start_acc)               rem <= len_q;
      else if (emit)               rem <= rem - LEN_W'(1);
      if (flush) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (pop) begin
        sr      <= mem[rptr[AW-1:0]];
        bit_cnt <= 6'd32;
      end else if (emit) begin
        sr      <= sr >> 1;
        bit_cnt <= bit_cnt - 6'd1;
      end
      if (clr_err)                  ovf <= 1'b0;
      else if (push && !push_ok)    ovf <= 1'b1;
    end
  end

`ifdef PROG_CRC_EN
  logic [15:0] crc;
  // Bit-serial CRC-16-CCITT over emitted bits, re-seeded on each accepted START.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || start_acc) crc <= 16'hFFFF;
    else if (emit) crc <= {crc[14:0], 1'b0} ^ ({16{crc[15] ^ prog_din}} & 16'h1021);
  end
`endif

  // Register read mux, sampled at the hit and returned with ack.
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata[4:0] = {ovf, busy, empty, full, prog_done};
      2'd1: rdata[LEN_W-1:0] = len_q;
      2'd3: begin
        rdata[LEN_W-1:0] = rem;
`ifdef PROG_CRC_EN
        rdata[31:16] = crc;
`endif
      end
      default: rdata = '0;
    endcase
  end

  // Registered single-cycle ack; read data is driven only alongside ack.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
    end else begin
      wb.wbs_ack_o <= hit;
      wb.wbs_dat_o <= (hit && !wb.wbs_we_i) ? rdata : 32'h0;
    end
  end
endmodule

// File: tb/tb_prga_prog_ctrl.sv
// Self-checking bench for prga_prog_ctrl, using directed scenarios and a randomized stream loop.
// The reference model builds the expected bit stream from the pushed words and computes the golden CRC-16-CCITT.
// A negedge monitor records every emitted bit and prog_rst cycle for comparison.
module tb_prga_prog_ctrl;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_LEN  = BASE + 32'd4;
  localparam logic [31:0] A_DATA = BASE + 32'd8;
  localparam logic [31:0] A_STAT = BASE + 32'd12;
`ifdef PROG_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic prog_rst, prog_we, prog_din, prog_done, irq;

  prga_prog_ctrl_if wb();

  prga_prog_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .RST_CYCLES(4), .LEN_W(24)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb       (wb),
    .prog_rst (prog_rst),
    .prog_we  (prog_we),
    .prog_din (prog_din),
    .prog_done(prog_done),
    .irq      (irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_errors = 0;
  bit bit_q[$];
  int rst_total = 0;
  int viol = 0;

  // Monitor: record the serial stream and prog_rst cycles; a bit must never be strobed in reset or done.
  always @(negedge wb_clk_i) begin
    if (prog_we) bit_q.push_back(prog_din);
    if (prog_rst) rst_total++;
    if (prog_we && (prog_rst || prog_done)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bit b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) c = (c[15] ^ b[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  function automatic logic [31:0] exp_status(input logic [31:0] rem, input logic [15:0] crc);
    return CRC_ON ? {crc, rem[15:0]} : rem;
  endfunction

  // First len bits of the word sequence, LSB first within each word.
  function automatic void build_bits(input logic [31:0] w[$], input int len, output bit q[$]);
    q = {};
    for (int i = 0; i < len; i++) q.push_back(w[i / 32][i % 32]);
  endfunction

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int n;
    @(negedge wb_clk_i);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wdat;
    n = 0;
    do begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end while (!wb.wbs_ack_o && n < 20);
    rdat = wb.wbs_dat_o;
    if (!wb.wbs_ack_o) check("ack_timeout", 32'(wb.wbs_ack_o), 32'd1);
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, 32'h0, d);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!prog_done && n < 600) begin
      @(negedge wb_clk_i);
      n++;
    end
    check({tag, "_done"}, 32'(prog_done), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int base, input bit exp[$]);
    int mism;
    mism = 0;
    check({tag, "_nbits"}, 32'(bit_q.size() - base), 32'(exp.size()));
    foreach (exp[i])
      if (base + i < bit_q.size() && bit_q[base + i] != exp[i]) mism++;
    check({tag, "_bitmism"}, 32'(mism), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] w[$];
    bit          exp[$];
    int          base, rbase, len, nw, seen;

    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = '0;
    wb.wbs_dat_i = '0;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Reset state
    check("rst_outs", {27'b0, prog_rst, prog_we, prog_din, prog_done, irq}, 32'h0);
    check("rst_ack", {31'b0, wb.wbs_ack_o}, 32'h0);
    wb_rd(A_CTRL, r);
    check("rst_ctrl", r, 32'h4);
    wb_rd(A_LEN, r);
    check("rst_len", r, 32'h0);

    // Non-hit never acked
    @(negedge wb_clk_i);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_adr_i = BASE + 32'h10;
    seen = 0;
    repeat (5) begin
      @(posedge wb_clk_i);
      #1;
      if (wb.wbs_ack_o) seen++;
    end
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    check("nohit_ack", 32'(seen), 32'd0);

    // LEN=40 example stream
    w = '{32'hA5A5_0F0F, 32'h0000_00C3};
    wb_wr(A_LEN, 32'd40);
    wb_wr(A_DATA, w[0]);
    wb_wr(A_DATA, w[1]);
    base = bit_q.size();
    rbase = rst_total;
    wb_wr(A_CTRL, 32'h1);
    wait_done("ex40");
    build_bits(w, 40, exp);
    check_stream("ex40", base, exp);
    check("ex40_rstcyc", 32'(rst_total - rbase), 32'd4);
    check("ex40_irq", 32'(irq), 32'd1);
    wb_rd(A_STAT, r);
    check("ex40_status", r, exp_status(32'd0, crc16(exp)));
    wb_rd(A_CTRL, r);
    check("ex40_ctrl", r, 32'h5);

    // Stall on empty FIFO
    wb_wr(A_LEN, 32'd64);
    base = bit_q.size();
    rbase = rst_total;
    wb_wr(A_CTRL, 32'h1);
    repeat (20) @(posedge wb_clk_i);
    check("stall_nbits", 32'(bit_q.size() - base), 32'd0);
    check("stall_rstcyc", 32'(rst_total - rbase), 32'd4);
    wb_wr(A_LEN, 32'd7);
    wb_rd(A_LEN, r);
    check("busy_len_ignored", r, 32'd64);
    wb_rd(A_CTRL, r);
    check("stall_ctrl", r, 32'h0C);
    w = '{$urandom()};
    wb_wr(A_DATA, w[0]);
    repeat (45) @(posedge wb_clk_i);
    build_bits(w, 32, exp);
    check_stream("stall", base, exp);
    wb_rd(A_STAT, r);
    check("stall_status", r, exp_status(32'd32, crc16(exp)));
    wb_rd(A_CTRL, r);
    check("stall_ctrl2", r, 32'h0C);

    // ABORT beats START mid-stream
    wb_wr(A_DATA, $urandom());
    repeat (10) @(posedge wb_clk_i);
    wb_wr(A_CTRL, 32'h3);
    check("abort_outs", {29'b0, prog_rst, prog_we, prog_done}, 32'h0);
    wb_rd(A_CTRL, r);
    check("abort_ctrl", r, 32'h4);

    // START with LEN=0
    wb_wr(A_LEN, 32'd0);
    base = bit_q.size();
    rbase = rst_total;
    wb_wr(A_CTRL, 32'h1);
    repeat (10) @(posedge wb_clk_i);
    check("len0_rstcyc", 32'(rst_total - rbase), 32'd4);
    check("len0_nbits", 32'(bit_q.size() - base), 32'd0);
    check("len0_done", 32'(prog_done), 32'd1);
    wb_rd(A_STAT, r);
    check("len0_status", r, exp_status(32'd0, 16'hFFFF));

    // Overflow: 5 pushes into a 4-deep FIFO
    wb_wr(A_CTRL, 32'h2);
    w = {};
    for (int i = 0; i < 5; i++) begin
      w.push_back($urandom());
      wb_wr(A_DATA, w[i]);
    end
    wb_rd(A_CTRL, r);
    check("ovf_ctrl", r, 32'h12);
    check("ovf_irq", 32'(irq), 32'd1);
    wb_rd(A_DATA, r);
    check("data_read", r, 32'h0);
    wb_wr(A_CTRL, 32'h4);
    wb_rd(A_CTRL, r);
    check("clrerr_ctrl", r, 32'h02);
    check("clrerr_irq", 32'(irq), 32'd0);
    wb_wr(A_LEN, 32'd128);
    base = bit_q.size();
    wb_wr(A_CTRL, 32'h1);
    wait_done("ovf128");
    build_bits(w, 128, exp);
    check_stream("ovf128", base, exp);

    // CRC of 8 zero bits
    w = '{32'h0};
    wb_wr(A_LEN, 32'd8);
    wb_wr(A_DATA, 32'h0);
    base = bit_q.size();
    wb_wr(A_CTRL, 32'h1);
    wait_done("crc8");
    build_bits(w, 8, exp);
    check_stream("crc8", base, exp);
    wb_rd(A_STAT, r);
    check("crc8_status", r, exp_status(32'd0, crc16(exp)));

    // Randomized streams; unused trailing words must be flushed
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 128);
      nw = (len + 31) / 32;
      nw = nw + $urandom_range(0, 4 - nw);
      w = {};
      for (int i = 0; i < nw; i++) w.push_back($urandom());
      wb_wr(A_LEN, 32'(len));
      for (int i = 0; i < nw; i++) wb_wr(A_DATA, w[i]);
      base = bit_q.size();
      rbase = rst_total;
      wb_wr(A_CTRL, 32'h1);
      wait_done("rnd");
      build_bits(w, len, exp);
      check_stream("rnd", base, exp);
      check("rnd_rstcyc", 32'(rst_total - rbase), 32'd4);
      wb_rd(A_CTRL, r);
      check("rnd_ctrl", r, 32'h5);
      wb_rd(A_STAT, r);
      check("rnd_status", r, exp_status(32'd0, crc16(exp)));
    end

    // Reset mid-stream
    wb_wr(A_LEN, 32'd64);
    wb_wr(A_DATA, $urandom());
    wb_wr(A_DATA, $urandom());
    wb_wr(A_CTRL, 32'h1);
    repeat (12) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i);
    #1;
    check("midrst_outs", {26'b0, prog_rst, prog_we, prog_din, prog_done, irq, wb.wbs_ack_o}, 32'h0);
    check("midrst_dat", wb.wbs_dat_o, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    wb_rd(A_CTRL, r);
    check("midrst_ctrl", r, 32'h4);
    wb_rd(A_LEN, r);
    check("midrst_len", r, 32'h0);

    check("we_in_rst_or_done", 32'(viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
